// File: rtl/axi_stream_arb_pkg.sv
// Shared types and helpers for the AXI Stream round-robin arbiter.
package axi_stream_arb_pkg;

  typedef enum logic [0:0] {
    Idle   = 1'b0,
    Locked = 1'b1
  } arb_state_t;

  // Wrapped increment of a source index over n sources.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

  // Zero-width sideband fields are carried as a single unused bit.
  function automatic int unsigned field_bits(input int unsigned w);
    return (w > 0) ? w : 32'd1;
  endfunction

endpackage

// File: rtl/axi_stream_bus.sv
// AXI Stream bus interface. Modports are named after the peer on the far side:
// Tx is the port facing a transmitter, Rx the port facing a receiver.
interface AXI_STREAM_BUS
  import axi_stream_arb_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IdWidth   = 0,
  parameter int unsigned DestWidth = 0,
  parameter int unsigned UserWidth = 0
);
  localparam int unsigned DataBits = field_bits(DataWidth);
  localparam int unsigned StrbBits = field_bits(DataWidth / 8);
  localparam int unsigned IdBits   = field_bits(IdWidth);
  localparam int unsigned DestBits = field_bits(DestWidth);
  localparam int unsigned UserBits = field_bits(UserWidth);

  logic                tvalid;
  logic                tready;
  logic [DataBits-1:0] tdata;
  logic [StrbBits-1:0] tstrb;
  logic [StrbBits-1:0] tkeep;
  logic                tlast;
  logic [IdBits-1:0]   tid;
  logic [DestBits-1:0] tdest;
  logic [UserBits-1:0] tuser;

  modport Tx (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
  modport Rx (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);

endinterface

// File: rtl/axi_stream_rr_pick.sv
// Combinational round-robin picker: first valid index at or above prio, wrapping.
module axi_stream_rr_pick #(
  parameter int unsigned NumInputs = 4,
  localparam int unsigned IdxWidth = $clog2(NumInputs)
) (
  input  logic [NumInputs-1:0] valid,
  input  logic [IdxWidth-1:0]  prio,
  output logic [IdxWidth-1:0]  pick_idx,
  output logic                 any_valid
);

  logic [IdxWidth:0] cand;
  logic              found;

  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < NumInputs; i++) begin
      cand = {1'b0, prio} + (IdxWidth + 1)'(i);
      if (cand >= (IdxWidth + 1)'(NumInputs)) cand = cand - (IdxWidth + 1)'(NumInputs);
      if (!found && valid[cand[IdxWidth-1:0]]) begin
        pick_idx = cand[IdxWidth-1:0];
        found    = 1'b1;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-granular round-robin AXI Stream arbiter with zero-latency forwarding.
// Optional: define AXI_STREAM_ARB_TID_TAG_EN to replace tid with the source index.
//
// state  | meaning
// Idle   | no packet in flight; picker chooses combinationally, single beats pass straight through
// Locked | grant frozen on grant_idx_q until that source's tlast beat is accepted
module axi_stream_rr_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IdWidth   = 0,
  parameter int unsigned DestWidth = 0,
  parameter int unsigned UserWidth = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  AXI_STREAM_BUS.Tx            axis_in [NumInputs],
  AXI_STREAM_BUS.Rx            axis_out,
  output logic [NumInputs-1:0] grant_o,
  output logic                 busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumInputs);
  localparam int unsigned DataBits = field_bits(DataWidth);
  localparam int unsigned StrbBits = field_bits(DataWidth / 8);
  localparam int unsigned IdBits   = field_bits(IdWidth);
  localparam int unsigned DestBits = field_bits(DestWidth);
  localparam int unsigned UserBits = field_bits(UserWidth);

  if (NumInputs < 2) begin : g_chk_inputs
    $fatal(1, "axi_stream_rr_arbiter: NumInputs must be >= 2");
  end
  if (DataWidth % 8 != 0) begin : g_chk_data
    $fatal(1, "axi_stream_rr_arbiter: DataWidth must be a multiple of 8");
  end
`ifdef AXI_STREAM_ARB_TID_TAG_EN
  if (IdWidth < IdxWidth) begin : g_chk_tid
    $fatal(1, "axi_stream_rr_arbiter: IdWidth too narrow to tag the source index");
  end
`endif

  arb_state_t           state_q;
  logic [IdxWidth-1:0]  prio_q, grant_idx_q, pick_idx, cur_idx;
  logic                 any_valid, active, beat_done, cur_last;
  logic [NumInputs-1:0] in_valid, in_last;
  logic [DataBits-1:0]  in_data [NumInputs];
  logic [StrbBits-1:0]  in_strb [NumInputs];
  logic [StrbBits-1:0]  in_keep [NumInputs];
  logic [DestBits-1:0]  in_dest [NumInputs];
  logic [UserBits-1:0]  in_user [NumInputs];
`ifndef AXI_STREAM_ARB_TID_TAG_EN
  logic [IdBits-1:0]    in_id   [NumInputs];
`endif

  for (genvar i = 0; i < NumInputs; i++) begin : g_in
    assign in_valid[i] = axis_in[i].tvalid;
    assign in_last[i]  = axis_in[i].tlast;
    assign in_data[i]  = axis_in[i].tdata;
    assign in_strb[i]  = axis_in[i].tstrb;
    assign in_keep[i]  = axis_in[i].tkeep;
    assign in_dest[i]  = axis_in[i].tdest;
    assign in_user[i]  = axis_in[i].tuser;
`ifndef AXI_STREAM_ARB_TID_TAG_EN
    assign in_id[i]    = axis_in[i].tid;
`endif
    assign axis_in[i].tready = grant_o[i] & axis_out.tready;
  end

  axi_stream_rr_pick #(.NumInputs(NumInputs)) u_pick (
    .valid     (in_valid),
    .prio      (prio_q),
    .pick_idx  (pick_idx),
    .any_valid (any_valid)
  );

  assign cur_idx   = (state_q == Locked) ? grant_idx_q : pick_idx;
  assign cur_last  = in_last[cur_idx];
  assign beat_done = in_valid[cur_idx] & axis_out.tready;

  // Reset also blanks the combinational outputs, since Idle would otherwise grant a valid source.
  assign active  = rst_ni & ((state_q == Locked) | any_valid);
  assign grant_o = active ? (NumInputs'(1) << cur_idx) : '0;
  assign busy_o  = (state_q == Locked);

  assign axis_out.tvalid = active & in_valid[cur_idx];
  assign axis_out.tlast  = active & cur_last;
  assign axis_out.tdata  = active ? in_data[cur_idx] : '0;
  assign axis_out.tstrb  = active ? in_strb[cur_idx] : '0;
  assign axis_out.tkeep  = active ? in_keep[cur_idx] : '0;
  assign axis_out.tdest  = active ? in_dest[cur_idx] : '0;
  assign axis_out.tuser  = active ? in_user[cur_idx] : '0;
`ifdef AXI_STREAM_ARB_TID_TAG_EN
  assign axis_out.tid    = active ? IdBits'(cur_idx) : '0;
`else
  assign axis_out.tid    = active ? in_id[cur_idx] : '0;
`endif

  // A stalled first beat still locks, so the presented data never switches source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      prio_q      <= '0;
      grant_idx_q <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (any_valid) begin
            if (beat_done && cur_last) begin
              prio_q <= IdxWidth'(rr_next(32'(pick_idx), NumInputs));
            end else begin
              state_q     <= Locked;
              grant_idx_q <= pick_idx;
            end
          end
        end
        Locked: begin
          if (beat_done && cur_last) begin
            state_q <= Idle;
            prio_q  <= IdxWidth'(rr_next(32'(grant_idx_q), NumInputs));
          end
        end
      endcase
    end
  end

endmodule
